// File: rtl/logicnet_pipe_ctrl_pkg.sv
// Shared constants and helpers for the LogicNets layer-chain pipeline controller.
package logicnet_ctrl_pkg;

    localparam int DEF_NUM_STAGES = 4;
    localparam int DEF_CNT_W      = 32;

    // Bits needed to count 0..n valid stages.
    function automatic int occ_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/logicnet_pipe_ctrl_if.sv
// Handshake/enable bundle between the layer-chain wrapper and the pipeline controller.
interface logicnet_pipe_ctrl_if
    import logicnet_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES
);
    logic                               in_valid;
    logic                               in_ready;
    logic                               flush;
    logic                               out_valid;
    logic                               out_ready;
    logic [NUM_STAGES-1:0]              stage_en;
    logic [NUM_STAGES-1:0]              stage_valid;
    logic [occ_w(NUM_STAGES)-1:0]       occupancy;

    modport master (
        output in_valid, flush, out_ready,
        input  in_ready, out_valid, stage_en, stage_valid, occupancy
    );

    modport slave (
        input  in_valid, flush, out_ready,
        output in_ready, out_valid, stage_en, stage_valid, occupancy
    );
endinterface

// File: rtl/logicnet_pipe_ctrl_vbit.sv
// One valid-bit cell of the pipeline: tracks whether its layer register holds a sample.
module logicnet_pipe_vbit
    import logicnet_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic up,
    input  logic rdy_next,
    input  logic flush,
    output logic v,
    output logic rdy,
    output logic en
);
    logic v_q, v_d;

    // An empty stage always accepts, so bubbles collapse under backpressure.
    assign rdy = !v_q || rdy_next;
    assign en  = up && rdy && !flush;
    assign v   = v_q;

    always_comb begin
        v_d = 1'b0;
        if (flush)                v_d = 1'b0;
        else if (en)              v_d = 1'b1;
        else if (v_q && !rdy_next) v_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) v_q <= 1'b0;
        else     v_q <= v_d;
    end
endmodule

// File: rtl/logicnet_pipe_ctrl.sv
// Valid/ready clock-enable controller for the registered LogicNets layer chain.
// Optional saturating performance counters are built when LOGICNET_PERF_CNT_EN is defined.
module logicnet_pipe_ctrl
    import logicnet_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int CNT_W      = DEF_CNT_W
)(
    input  logic                 clk,
    input  logic                 rst,
    logicnet_pipe_ctrl_if.slave  pif
`ifdef LOGICNET_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     perf_in_cnt,
    output logic [CNT_W-1:0]     perf_out_cnt,
    output logic [CNT_W-1:0]     perf_stall_cnt
`endif
);
    localparam int OCC_W = occ_w(NUM_STAGES);

    logic [NUM_STAGES:0]   rdy;
    logic [NUM_STAGES-1:0] up, v, en;
    logic                  in_fire, out_fire;
    logic [OCC_W-1:0]      occ_q, occ_d;

    assign rdy[NUM_STAGES] = pif.out_ready;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign up[i] = pif.in_valid;
        end else begin : g_body
            assign up[i] = v[i-1];
        end

        logicnet_pipe_vbit u_vbit (
            .clk      (clk),
            .rst      (rst),
            .up       (up[i]),
            .rdy_next (rdy[i+1]),
            .flush    (pif.flush),
            .v        (v[i]),
            .rdy      (rdy[i]),
            .en       (en[i])
        );
    end

    assign pif.in_ready    = rdy[0] && !pif.flush;
    assign pif.stage_en    = en;
    assign pif.stage_valid = v;
    assign pif.out_valid   = v[NUM_STAGES-1];
    assign pif.occupancy   = occ_q;

    assign in_fire  = en[0];
    assign out_fire = v[NUM_STAGES-1] && pif.out_ready && !pif.flush;

    // Internal hand-offs conserve the count, so only the ends change occupancy.
    always_comb begin
        occ_d = occ_q;
        if (pif.flush) occ_d = '0;
        else           occ_d = occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);
    end

    always_ff @(posedge clk) begin
        if (rst) occ_q <= '0;
        else     occ_q <= occ_d;
    end

`ifdef LOGICNET_PERF_CNT_EN
    logic [CNT_W-1:0] perf_in_q, perf_out_q, perf_stall_q;
    logic             stall;

    assign stall = v[NUM_STAGES-1] && !pif.out_ready;

    // Counters saturate and survive flush; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_in_q    <= '0;
            perf_out_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (in_fire  && !(&perf_in_q))    perf_in_q    <= perf_in_q    + CNT_W'(1);
            if (out_fire && !(&perf_out_q))   perf_out_q   <= perf_out_q   + CNT_W'(1);
            if (stall    && !(&perf_stall_q)) perf_stall_q <= perf_stall_q + CNT_W'(1);
        end
    end

    assign perf_in_cnt    = perf_in_q;
    assign perf_out_cnt   = perf_out_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = |CNT_W;
`endif
endmodule

// File: tb/tb_logicnet_pipe_ctrl.sv
// Directed scoreboard bench for logicnet_pipe_ctrl (NUM_STAGES=4).
module tb_logicnet_pipe_ctrl;
    import logicnet_ctrl_pkg::*;

    localparam int N     = 4;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logicnet_pipe_ctrl_if #(.NUM_STAGES(N)) ifc ();

`ifdef LOGICNET_PERF_CNT_EN
    logic [CNT_W-1:0] perf_in_cnt, perf_out_cnt, perf_stall_cnt;
`endif

    logicnet_pipe_ctrl #(.NUM_STAGES(N), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .pif            (ifc.slave)
`ifdef LOGICNET_PERF_CNT_EN
        ,
        .perf_in_cnt    (perf_in_cnt),
        .perf_out_cnt   (perf_out_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int sb[$];   // expected cycle index of each output transfer

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every accepted output must land on the cycle the stimulus predicted.
    always @(negedge clk) begin
        if (rst === 1'b0 && ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1 && ifc.flush === 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_xfer: transfer at cycle %0d, expected none", cyc);
            end else begin
                int e;
                e = sb.pop_front();
                chk("out_xfer_cycle", cyc, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifc.flush = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int c0;

    initial begin
        rst = 1'b1;
        ifc.flush = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b0;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_stage_valid", 32'(ifc.stage_valid), 32'h0);
        chk("rst_out_valid", 32'(ifc.out_valid), 32'h0);
        chk("rst_occupancy", 32'(ifc.occupancy), 32'h0);
        chk("rst_in_ready", 32'(ifc.in_ready), 32'h1);
`ifdef LOGICNET_PERF_CNT_EN
        chk("rst_perf_in", perf_in_cnt, 32'h0);
`endif

        // Single sample walks one stage per cycle
        do_reset();
        c0 = cyc;
        ifc.out_ready = 1'b1;
        ifc.in_valid = 1'b1;
        sb.push_back(c0 + 4);
        @(negedge clk);
        chk("single_en_c0", 32'(ifc.stage_en), 32'h1);
        tick();
        ifc.in_valid = 1'b0;
        for (int i = 1; i < N; i++) begin
            @(negedge clk);
            chk("single_en_ci", 32'(ifc.stage_en), 32'(1 << i));
            tick();
        end
        @(negedge clk);
        chk("single_out_valid_c4", 32'(ifc.out_valid), 32'h1);
        chk("single_en_c4", 32'(ifc.stage_en), 32'h0);
        tick();
        @(negedge clk);
        chk("single_out_valid_c5", 32'(ifc.out_valid), 32'h0);
        chk("single_occ_c5", 32'(ifc.occupancy), 32'h0);

        // Stream of 10 back-to-back samples
        do_reset();
        c0 = cyc;
        ifc.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            ifc.in_valid = 1'b1;
            sb.push_back(c0 + 4 + k);
            @(negedge clk);
            chk("stream_in_ready", 32'(ifc.in_ready), 32'h1);
            tick();
        end
        ifc.in_valid = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        chk("stream_drained_occ", 32'(ifc.occupancy), 32'h0);
`ifdef LOGICNET_PERF_CNT_EN
        chk("stream_perf_in", perf_in_cnt, 32'd10);
        chk("stream_perf_out", perf_out_cnt, 32'd10);
`endif

        // Backpressure: fill, stall three cycles, then release
        do_reset();
        c0 = cyc;
        ifc.out_ready = 1'b0;
        ifc.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sb.push_back(c0 + 7 + k);
            @(negedge clk);
            chk("fill_in_ready", 32'(ifc.in_ready), 32'h1);
            tick();
        end
        @(negedge clk);
        chk("full_occ", 32'(ifc.occupancy), 32'd4);
        chk("full_in_ready", 32'(ifc.in_ready), 32'h0);
        chk("full_out_valid", 32'(ifc.out_valid), 32'h1);
        tick();
        tick();
        @(negedge clk);
        chk("stall_in_ready", 32'(ifc.in_ready), 32'h0);
        tick();
        ifc.out_ready = 1'b1;
        sb.push_back(c0 + 11);
        @(negedge clk);
        chk("release_in_ready", 32'(ifc.in_ready), 32'h1);
        tick();
        ifc.in_valid = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        chk("release_drained_occ", 32'(ifc.occupancy), 32'h0);
`ifdef LOGICNET_PERF_CNT_EN
        chk("bp_perf_in", perf_in_cnt, 32'd5);
        chk("bp_perf_out", perf_out_cnt, 32'd5);
        chk("bp_perf_stall", perf_stall_cnt, 32'd3);
`endif

        // Bubble collapse, then flush with three samples in flight
        do_reset();
        ifc.out_ready = 1'b0;
        ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        tick();
        tick();
        ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("bubble_stage_valid", 32'(ifc.stage_valid), 32'hC);
        chk("bubble_occ", 32'(ifc.occupancy), 32'd2);
        ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        tick();
        ifc.flush = 1'b1;
        ifc.out_ready = 1'b1;
        ifc.in_valid = 1'b1;
        @(negedge clk);
        chk("preflush_stage_valid", 32'(ifc.stage_valid), 32'hE);
        chk("preflush_occ", 32'(ifc.occupancy), 32'd3);
        chk("flush_out_valid", 32'(ifc.out_valid), 32'h1);
        chk("flush_in_ready", 32'(ifc.in_ready), 32'h0);
        chk("flush_stage_en", 32'(ifc.stage_en), 32'h0);
        tick();
        ifc.flush = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b0;
        @(negedge clk);
        chk("postflush_stage_valid", 32'(ifc.stage_valid), 32'h0);
        chk("postflush_out_valid", 32'(ifc.out_valid), 32'h0);
        chk("postflush_occ", 32'(ifc.occupancy), 32'h0);
`ifdef LOGICNET_PERF_CNT_EN
        chk("flush_perf_in", perf_in_cnt, 32'd3);
        chk("flush_perf_out", perf_out_cnt, 32'd0);
        chk("flush_perf_stall", perf_stall_cnt, 32'd4);
`endif

        // Reset mid-stream with the pipe full
        do_reset();
        ifc.out_ready = 1'b0;
        ifc.in_valid = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("prerst_occ", 32'(ifc.occupancy), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifc.in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_stage_valid", 32'(ifc.stage_valid), 32'h0);
        chk("midrst_out_valid", 32'(ifc.out_valid), 32'h0);
        chk("midrst_occ", 32'(ifc.occupancy), 32'h0);
        chk("midrst_in_ready", 32'(ifc.in_ready), 32'h1);
`ifdef LOGICNET_PERF_CNT_EN
        chk("midrst_perf_in", perf_in_cnt, 32'h0);
        chk("midrst_perf_stall", perf_stall_cnt, 32'h0);
`endif

        tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/logicnet_pipe_ctrl.md
# logicnet_pipe_ctrl

Valid/ready pipeline controller for the registered LogicNets layer chain. Each layer's neuron LUTs are purely combinational, so the layer output registers need clock enables that follow the flow of samples. This block tracks one valid bit per layer register stage and generates those enables. It provides full-throughput streaming with backpressure from the downstream classifier/consumer, plus a synchronous flush. It sits beside the layer chain in the top-level network wrapper and carries no data itself.

## Interface
- NUM_STAGES, 4, number of registered layer stages (≥1)
- CNT_W, 32, width of performance counters (used only with LOGICNET_PERF_CNT_EN)
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset: synchronous, active-high
- in_valid  input  1  a sample is presented at the stage-0 input
- in_ready  output  1  stage 0 accepts the sample this cycle
- flush  input  1  synchronous drop of all in-flight samples
- stage_en  output  NUM_STAGES  clock enable for layer register i
- stage_valid  output  NUM_STAGES  stage i holds a valid sample
- out_valid  output  1  last stage holds a valid sample
- out_ready  input  1  consumer takes the sample this cycle
- occupancy  output  $clog2(NUM_STAGES+1)  number of valid stages
- perf_in_cnt, perf_out_cnt, perf_stall_cnt  output  CNT_W each  (only with LOGICNET_PERF_CNT_EN)

## Operation
- State: v[NUM_STAGES-1:0], the valid bits.
- Ready chain (combinational): rdy[NUM_STAGES] = out_ready; rdy[i] = !v[i] || rdy[i+1].
- in_ready = rdy[0] && !flush.
- Upstream valid: up[0] = in_valid; up[i] = v[i-1].
- stage_en[i] = up[i] && rdy[i] && !flush.
- Next v[i]:
  - flush → 0
  - stage_en[i] → 1
  - v[i] && !rdy[i+1] → 1 (hold)
  - otherwise 0
- out_valid = v[NUM_STAGES-1]. A transfer occurs when out_valid && out_ready.
- stage_valid = v. occupancy = popcount(v), registered alongside v.
- Bubbles collapse: a stage with v=0 always accepts, even when downstream is stalled.
- Simultaneous accept into stage i and departure from stage i in the same cycle: v[i] stays 1. There is no bubble, which gives full throughput.
- flush has priority over in_valid and out_ready. During a flush cycle all stage_en=0, in_ready=0, and no transfer is counted. out_valid may be high while flush=1, but the sample is discarded.
- rst behaves like flush and also clears the counters. It is legal mid-stream; in-flight samples are lost.

## Timing
- Reset values: v=0, stage_valid=0, out_valid=0, occupancy=0, perf counters=0. After reset, in_ready=1 combinationally (when flush=0).
- Latency: a sample accepted at edge k appears with out_valid=1 in the cycle after edge k+NUM_STAGES-1. That is NUM_STAGES cycles from the in_valid cycle to the out_valid cycle, with no stall.
- Throughput: 1 sample/cycle while out_ready=1.
- in_ready, stage_en and out_valid have combinational paths from out_ready and in_valid. The ready chain depth is NUM_STAGES.
- Full: occupancy=NUM_STAGES and out_ready=0 → in_ready=0.
- Empty: occupancy=0 → out_valid=0.

## Configuration
- LOGICNET_PERF_CNT_EN defined:
  - perf_in_cnt increments on each in_valid && in_ready.
  - perf_out_cnt increments on each out_valid && out_ready && !flush.
  - perf_stall_cnt increments on each cycle with out_valid && !out_ready.
  - All three saturate at 2^CNT_W-1 and clear only on rst (not on flush).
- Undefined: the counters and their ports are absent. Control behaviour is identical.

## Structure
- Package logicnet_ctrl_pkg holds:
  - the default NUM_STAGES and CNT_W constants;
  - a function for the occupancy width.
- Sub-module logicnet_pipe_vbit: one valid-bit cell with inputs up, rdy_next, flush, rst and outputs v, rdy, en. It is instantiated NUM_STAGES times in a generate loop.
- The counters are inline under the macro.

## Test plan
- Single sample, NUM_STAGES=4: in_valid=1 for cycle 0, out_ready=1 → stage_en[i] high in cycle i; out_valid=1 in cycle 4 only; occupancy returns to 0.
- Stream of 10 back-to-back samples, out_ready=1 → in_ready stays 1 throughout; out_valid=1 for cycles 4..13; perf_in_cnt=perf_out_cnt=10.
- out_ready=0 with continuous in_valid → 4 accepts, then in_ready=0 and occupancy=4; perf_stall_cnt increments each stalled cycle. Raise out_ready → one output per cycle and in_ready=1 again in the same cycle.
- Bubble collapse: sample A, 2 idle cycles, sample B, with out_ready=0 → A reaches stage 3 and B reaches stage 2 (v=4'b1100), occupancy=2.
- flush with occupancy=3 and out_valid=1 → next cycle v=0 and out_valid=0; perf_out_cnt unchanged; in_ready=0 during the flush cycle.
- rst asserted mid-stream with occupancy=4 → next cycle all outputs at reset values, counters 0, and in_ready=1.
